// File: rtl/data_ram_pkg.sv
// ---------------------------------------------------------------------------
// data_ram_pkg
// Shared definitions for the r1 byte-lane data memory.
//   SZ_BYTE / SZ_HALF / SZ_WORD : encodings of the req_size field
//                                 (2'b11 is also treated as a word)
//   lane_en()                   : byte-lane write enables for a store
//   is_misaligned()             : natural-alignment test for half/word accesses
// ---------------------------------------------------------------------------
package data_ram_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Lane enables for an access of the given size at byte offset lo.
    // A half picks the upper or lower lane pair from lo[1].
    function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] en;
        case (size)
            SZ_BYTE: en = 4'b0001 << lo;
            SZ_HALF: en = lo[1] ? 4'b1100 : 4'b0011;
            default: en = 4'b1111;
        endcase
        return en;
    endfunction

    // Half needs lo[0]=0, word needs lo=0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            default: bad = (lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ram_bank_r1.sv
// ---------------------------------------------------------------------------
// ram_bank_r1
// One byte-wide synchronous RAM bank with clock enable and registered read.
// Read-before-write when a write and read hit the same address in one cycle.
//   clk     : clock
//   en_i    : bank enable; nothing changes (including q_o) while low
//   wren_i  : write this bank's byte (qualified by en_i)
//   addr_i  : word address
//   d_i     : write byte
//   q_o     : registered read byte
// Contents are not reset and start uninitialised.
// ---------------------------------------------------------------------------
module ram_bank_r1 #(
    parameter int    DEPTH     = 256,
    parameter int    AW        = 8,
    parameter string INIT_FILE = "",
    parameter int    BANK      = 0
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          wren_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    d_i,
    output logic [7:0]    q_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] q_q;

    // Synchronous write and registered read, both gated by the bank enable.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (wren_i) begin
                mem_q[addr_i] <= d_i;
            end
            q_q <= mem_q[addr_i];
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/data_ram_r1.sv
// ---------------------------------------------------------------------------
// data_ram_r1
// Byte-lane data memory for the MIPS datapath with a valid/ready pipeline:
// stage 1 = bank read (plus lane writes), stage 2 = align/extend into the
// registered response. Misaligned half/word accesses can be reported as
// faults (ALIGN_CHECK=1) or silently aligned (ALIGN_CHECK=0).
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid / req_ready : request handshake
//   req_wren              : 1 store, 0 load
//   req_signed            : sign-extend loads
//   req_size              : 00 byte, 01 half, 1x word
//   req_addr              : byte address
//   req_wdata             : right-justified store data
//   rsp_valid / rsp_ready : response handshake
//   rsp_data              : load result (0 for stores and faults)
//   rsp_err               : alignment fault
//   rsp_store             : response belongs to a store
// ---------------------------------------------------------------------------
module data_ram_r1
    import data_ram_pkg::*;
#(
    parameter int    ADDR_W      = 10,
    parameter bit    ALIGN_CHECK = 1'b1,
    parameter string INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wren,
    input  logic              req_signed,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              rsp_store
);

    localparam int WA_W  = ADDR_W - 2;
    localparam int DEPTH = 1 << WA_W;

    logic            adv_s;
    logic            accept_s;
    logic            err_s;
    logic [1:0]      lo_s;
    logic [3:0]      lanes_s;
    logic [31:0]     wdata_rep_s;
    logic [3:0][7:0] q_s;
    logic [7:0]      byte_s;
    logic [15:0]     half_s;
    logic [31:0]     load_s;
    logic [31:0]     rsp_data_d;

    logic            s1_valid_q;
    logic [1:0]      s1_size_q;
    logic            s1_signed_q;
    logic [1:0]      s1_lo_q;
    logic            s1_err_q;
    logic            s1_store_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_data_q;
    logic            rsp_err_q;
    logic            rsp_store_q;

    // Both stages advance together whenever the response slot is free or draining.
    assign adv_s     = !rsp_valid_q || rsp_ready;
    assign accept_s  = req_valid && adv_s;
    assign req_ready = adv_s;

    // Request decode: fault detection, effective lane offset, lane enables, data replication.
    always_comb begin
        err_s = ALIGN_CHECK && is_misaligned(req_size, req_addr[1:0]);
        // With checking off the offending low bits are masked off; with it on
        // this only affects faulting requests, which never write.
        if (req_size[1]) begin
            lo_s = 2'b00;
        end else if (req_size == SZ_HALF) begin
            lo_s = {req_addr[1], 1'b0};
        end else begin
            lo_s = req_addr[1:0];
        end
        if (accept_s && req_wren && !err_s) begin
            lanes_s = lane_en(req_size, lo_s);
        end else begin
            lanes_s = 4'b0000;
        end
        case (req_size)
            SZ_BYTE: wdata_rep_s = {4{req_wdata[7:0]}};
            SZ_HALF: wdata_rep_s = {2{req_wdata[15:0]}};
            default: wdata_rep_s = req_wdata;
        endcase
    end

    generate
        for (genvar b = 0; b < 4; b++) begin : g_bank
            ram_bank_r1 #(
                .DEPTH     (DEPTH),
                .AW        (WA_W),
                .INIT_FILE (INIT_FILE),
                .BANK      (b)
            ) u_bank (
                .clk    (clk),
                .en_i   (accept_s),
                .wren_i (lanes_s[b]),
                .addr_i (req_addr[ADDR_W-1:2]),
                .d_i    (wdata_rep_s[8*b +: 8]),
                .q_o    (q_s[b])
            );
        end
    endgenerate

    // Lane select and zero/sign extension of the stage-1 read data.
    always_comb begin
        byte_s = q_s[s1_lo_q];
        half_s = s1_lo_q[1] ? {q_s[3], q_s[2]} : {q_s[1], q_s[0]};
        case (s1_size_q)
            SZ_BYTE: load_s = s1_signed_q ? {{24{byte_s[7]}}, byte_s} : {24'h000000, byte_s};
            SZ_HALF: load_s = s1_signed_q ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
            default: load_s = {q_s[3], q_s[2], q_s[1], q_s[0]};
        endcase
        if (s1_valid_q && !s1_err_q && !s1_store_q) begin
            rsp_data_d = load_s;
        end else begin
            rsp_data_d = 32'h00000000;
        end
    end

    // Stage-1 control registers and response registers; held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_size_q   <= 2'b00;
            s1_signed_q <= 1'b0;
            s1_lo_q     <= 2'b00;
            s1_err_q    <= 1'b0;
            s1_store_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h00000000;
            rsp_err_q   <= 1'b0;
            rsp_store_q <= 1'b0;
        end else if (adv_s) begin
            s1_valid_q  <= accept_s;
            s1_size_q   <= req_size;
            s1_signed_q <= req_signed;
            s1_lo_q     <= lo_s;
            s1_err_q    <= err_s;
            s1_store_q  <= req_wren;
            rsp_valid_q <= s1_valid_q;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= s1_valid_q && s1_err_q;
            rsp_store_q <= s1_valid_q && s1_store_q;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_store = rsp_store_q;

endmodule

// File: tb/tb_data_ram_r1.sv
// ---------------------------------------------------------------------------
// tb_data_ram_r1
// Directed scoreboard bench for data_ram_r1. dut0 has alignment checking on,
// dut1 has it off; sel1 routes the request/response stream to one of them.
// ---------------------------------------------------------------------------
module tb_data_ram_r1;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        store;
        logic [7:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_wren;
    logic        req_signed;
    logic [1:0]  req_size;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic        sel1;

    logic        rdy0, rdy1, v0, v1, e0, e1, s0, s1;
    logic [31:0] d0, d1;
    logic        mon_ready, mon_valid, mon_err, mon_store;
    logic [31:0] mon_data;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    data_ram_r1 #(.ADDR_W(10), .ALIGN_CHECK(1'b1), .INIT_FILE("")) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel1), .req_ready(rdy0),
        .req_wren(req_wren), .req_signed(req_signed), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v0), .rsp_ready(rsp_ready),
        .rsp_data(d0), .rsp_err(e0), .rsp_store(s0)
    );

    data_ram_r1 #(.ADDR_W(10), .ALIGN_CHECK(1'b0), .INIT_FILE("")) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel1), .req_ready(rdy1),
        .req_wren(req_wren), .req_signed(req_signed), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v1), .rsp_ready(rsp_ready),
        .rsp_data(d1), .rsp_err(e1), .rsp_store(s1)
    );

    assign mon_ready = sel1 ? rdy1 : rdy0;
    assign mon_valid = sel1 ? v1 : v0;
    assign mon_data  = sel1 ? d1 : d0;
    assign mon_err   = sel1 ? e1 : e0;
    assign mon_store = sel1 ? s1 : s0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every completed response handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mon_valid === 1'b1 && rsp_ready === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got data=%h err=%b store=%b with nothing pending",
                         mon_data, mon_err, mon_store);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (mon_data !== e.data || mon_err !== e.err || mon_store !== e.store) begin
                    errors++;
                    $display("FAIL rsp_tag%0d: got data=%h err=%b store=%b expected data=%h err=%b store=%b",
                             e.tag, mon_data, mon_err, mon_store, e.data, e.err, e.store);
                end
            end
        end
    end

    task automatic send(input logic wr, input logic sg, input logic [1:0] sz,
                        input logic [9:0] ad, input logic [31:0] wd,
                        input logic [31:0] ed, input logic ee, input logic [7:0] tag);
        int   n;
        exp_t e;
        req_valid  = 1'b1;
        req_wren   = wr;
        req_signed = sg;
        req_size   = sz;
        req_addr   = ad;
        req_wdata  = wd;
        n = 0;
        @(negedge clk);
        while (mon_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (mon_ready !== 1'b1) begin
            chk("accept_timeout", {31'd0, mon_ready}, 32'd1);
            req_valid = 1'b0;
        end else begin
            e.data  = ed;
            e.err   = ee;
            e.store = wr;
            e.tag   = tag;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_wren = 1'b0; req_signed = 1'b0;
        req_size = 2'b00; req_addr = 10'h000; req_wdata = 32'h0; rsp_ready = 1'b1; sel1 = 1'b0;
        #1;
        chk("rst_req_ready", {31'd0, rdy0}, 32'd1);
        chk("rst_rsp_valid", {31'd0, v0}, 32'd0);
        chk("rst_rsp_data", d0, 32'h0);
        chk("rst_rsp_err", {31'd0, e0}, 32'd0);
        chk("rst_rsp_store", {31'd0, s0}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: word store/load and latency
        send(1'b1, 1'b0, 2'b10, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, 8'd1);
        idle(3);
        send(1'b0, 1'b0, 2'b10, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 8'd2);
        chk("lat_after_accept", {31'd0, mon_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_next_edge", {31'd0, mon_valid}, 32'd1);
        idle(2);

        // 2: byte/half loads with extension
        send(1'b0, 1'b1, 2'b00, 10'h013, 32'h0, 32'hFFFFFFDE, 1'b0, 8'd3);
        send(1'b0, 1'b0, 2'b00, 10'h012, 32'h0, 32'h000000AD, 1'b0, 8'd4);
        send(1'b0, 1'b1, 2'b01, 10'h010, 32'h0, 32'hFFFFBEEF, 1'b0, 8'd5);

        // 3: partial stores followed immediately by loads
        send(1'b1, 1'b0, 2'b01, 10'h012, 32'h00001234, 32'h0, 1'b0, 8'd6);
        send(1'b0, 1'b0, 2'b10, 10'h010, 32'h0, 32'h1234BEEF, 1'b0, 8'd7);
        send(1'b1, 1'b0, 2'b00, 10'h011, 32'h00000077, 32'h0, 1'b0, 8'd8);
        send(1'b0, 1'b0, 2'b10, 10'h010, 32'h0, 32'h123477EF, 1'b0, 8'd9);

        // 4: alignment faults, then the unchecked instance
        send(1'b0, 1'b0, 2'b10, 10'h011, 32'h0, 32'h0, 1'b1, 8'd10);
        send(1'b1, 1'b0, 2'b01, 10'h013, 32'h0000AAAA, 32'h0, 1'b1, 8'd11);
        send(1'b0, 1'b0, 2'b10, 10'h010, 32'h0, 32'h123477EF, 1'b0, 8'd12);
        idle(3);
        sel1 = 1'b1;
        send(1'b1, 1'b0, 2'b10, 10'h020, 32'hCAFEF00D, 32'h0, 1'b0, 8'd13);
        send(1'b0, 1'b0, 2'b10, 10'h021, 32'h0, 32'hCAFEF00D, 1'b0, 8'd14);
        send(1'b0, 1'b1, 2'b01, 10'h023, 32'h0, 32'hFFFFCAFE, 1'b0, 8'd15);
        idle(3);
        sel1 = 1'b0;

        // 5: backpressure with three back-to-back loads
        rsp_ready = 1'b0;
        fork
            begin
                send(1'b0, 1'b0, 2'b10, 10'h010, 32'h0, 32'h123477EF, 1'b0, 8'd16);
                send(1'b0, 1'b0, 2'b00, 10'h011, 32'h0, 32'h00000077, 1'b0, 8'd17);
                send(1'b0, 1'b0, 2'b01, 10'h012, 32'h0, 32'h00001234, 1'b0, 8'd18);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                chk("bp_first_valid", {31'd0, mon_valid}, 32'd1);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("bp_ready_low", {31'd0, mon_ready}, 32'd0);
                    chk("bp_data_hold", mon_data, 32'h123477EF);
                end
                @(posedge clk); #1;
                rsp_ready = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("bp_drain_valid", {31'd0, mon_valid}, 32'd1);
                end
            end
        join
        idle(3);

        // 6: reset with two loads in flight
        rsp_ready = 1'b0;
        send(1'b0, 1'b0, 2'b10, 10'h010, 32'h0, 32'h123477EF, 1'b0, 8'd19);
        send(1'b0, 1'b0, 2'b10, 10'h010, 32'h0, 32'h123477EF, 1'b0, 8'd20);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_inflight_valid", {31'd0, mon_valid}, 32'd0);
        chk("rst_inflight_ready", {31'd0, mon_ready}, 32'd1);
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {31'd0, mon_valid}, 32'd0);
        end
        @(posedge clk); #1;
        send(1'b0, 1'b0, 2'b10, 10'h010, 32'h0, 32'h123477EF, 1'b0, 8'd21);
        idle(5);

        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
